// File: rtl/pt_pkg.sv
// Shared status codes and encoder-FSM state encoding for the PT2262 transmit scheduler.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pt_pkg;

    localparam logic [7:0] ST_ACK    = 8'h06;
    localparam logic [7:0] ST_NAK    = 8'h15;
    localparam logic [7:0] ST_ENC_TO = 8'h18;
    localparam logic [7:0] ST_GAP    = 8'h1A;
    localparam logic [7:0] ST_OVR    = 8'h1F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } enc_state_t;

endpackage

// File: rtl/pt_code_fifo.sv
// Code-word FIFO between the byte assembler and the encoder FSM, first-word-fall-through.
// Latency: a pushed word appears on head the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; callers watch full/empty.
module pt_code_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = level == LVL_FULL;
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pt_tx_sched.sv
// Packs UART bytes into 24-bit code words, replays each REPEATS times into pt_enc, reports status bytes.
// Latency: first enc_ld two cycles after the push of a word into an idle, empty scheduler.
// Backpressure: rx_ready = !fifo_full (full frames are NAKed); one status slot, later events collapse into overrun.
module pt_tx_sched
    import pt_pkg::*;
#(
    parameter int REPEATS     = 4,
    parameter int DEPTH       = 4,
    parameter int GAP_TIMEOUT = 2000,
    parameter int ENC_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    output logic                   enc_ld,
    output logic [23:0]            enc_ad,
    input  logic                   enc_done,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam int WW = $clog2(ENC_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(ENC_TIMEOUT - 1);
    localparam logic [3:0]    REP_LAST = 4'(REPEATS - 1);

    logic [1:0]    byte_cnt;
    logic [15:0]   part;
    logic [GW-1:0] gap_cnt;
    logic          frame_done;
    logic          push;
    logic          asm_nak;
    logic          gap_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [23:0]   head;

    assign frame_done = rx_valid && byte_cnt == 2'd2;
    assign push       = frame_done && !fifo_full;
    assign asm_nak    = frame_done && fifo_full;
    assign gap_hit    = !rx_valid && byte_cnt != 2'd0 && gap_cnt == GAP_LAST;
    assign rx_ready   = !fifo_full;

    // Bytes are always taken, even with rx_ready low; only the completed frame can be refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            part     <= 16'h0000;
            gap_cnt  <= '0;
        end else if (rx_valid) begin
            gap_cnt <= '0;
            case (byte_cnt)
                2'd0: begin
                    part[15:8] <= rx_data;
                    byte_cnt   <= 2'd1;
                end
                2'd1: begin
                    part[7:0] <= rx_data;
                    byte_cnt  <= 2'd2;
                end
                default: byte_cnt <= 2'd0;
            endcase
        end else if (gap_hit) begin
            byte_cnt <= 2'd0;
            gap_cnt  <= '0;
        end else if (byte_cnt != 2'd0) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    pt_code_fifo #(
        .WIDTH (24),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({part, rx_data}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    enc_state_t    state;
    enc_state_t    state_nxt;
    logic [3:0]    rep;
    logic [WW-1:0] wd;
    logic          enc_err;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!fifo_empty) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_WAIT;
            S_WAIT: begin
                if (enc_done) begin
                    state_nxt = (rep == REP_LAST) ? S_DONE : S_LOAD;
                end else if (wd == WD_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The watchdog gives WAIT exactly ENC_TIMEOUT cycles before giving up on the encoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            rep     <= 4'd0;
            wd      <= '0;
            enc_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    rep     <= 4'd0;
                    enc_err <= 1'b0;
                end
                S_LOAD: wd <= '0;
                S_WAIT: begin
                    wd <= wd + 1'b1;
                    if (enc_done) begin
                        if (rep != REP_LAST) rep <= rep + 1'b1;
                    end else if (wd == WD_LAST) begin
                        enc_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = state != S_IDLE;
    assign enc_ld = state == S_LOAD;
    assign enc_ad = busy ? head : 24'h000000;
    assign pop    = state == S_DONE;

    logic       tx_fire;
    logic       slot_free;
    logic       done_raise;
    logic       asm_raise;
    logic [7:0] done_code;
    logic [7:0] asm_code;
    logic       ld_vld;
    logic [7:0] ld_dat;
    logic       ovr_set;
    logic       ovr;

    assign tx_fire    = tx_valid && tx_ready;
    assign slot_free  = !tx_valid || tx_fire;
    assign done_raise = state == S_DONE;
    assign done_code  = enc_err ? ST_ENC_TO : ST_ACK;
    assign asm_raise  = asm_nak || gap_hit;
    assign asm_code   = asm_nak ? ST_NAK : ST_GAP;

    always_comb begin
        ld_vld  = 1'b0;
        ld_dat  = 8'h00;
        ovr_set = 1'b0;
        if (done_raise) begin
            ld_vld  = 1'b1;
            ld_dat  = done_code;
            ovr_set = asm_raise;
        end else if (asm_raise) begin
            ld_vld = 1'b1;
            ld_dat = asm_code;
        end
        if (ld_vld && !slot_free) ovr_set = 1'b1;
    end

    // Fresh events take the slot ahead of a pending overrun report, which drains afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            ovr      <= 1'b0;
        end else begin
            if (slot_free) begin
                if (ld_vld) begin
                    tx_valid <= 1'b1;
                    tx_data  <= ld_dat;
                end else if (ovr) begin
                    tx_valid <= 1'b1;
                    tx_data  <= ST_OVR;
                    ovr      <= 1'b0;
                end else begin
                    tx_valid <= 1'b0;
                end
            end
            if (ovr_set) ovr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pt_tx_sched.sv
// Scoreboard bench for pt_tx_sched: directed scenarios followed by randomized frame bursts.
// Expected code words and status bytes are queued at stimulus time and checked by independent processes.
module tb_pt_tx_sched;
    import pt_pkg::*;

    localparam int REPEATS = 4;
    localparam int DEPTH   = 4;
    localparam int GAP_TO  = 60;
    localparam int ENC_TO  = 100;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          enc_ld;
    logic [23:0]   enc_ad;
    logic          enc_done;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          busy;
    logic [LW-1:0] level;

    pt_tx_sched #(
        .REPEATS     (REPEATS),
        .DEPTH       (DEPTH),
        .GAP_TIMEOUT (GAP_TO),
        .ENC_TIMEOUT (ENC_TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .enc_ld   (enc_ld),
        .enc_ad   (enc_ad),
        .enc_done (enc_done),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .level    (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] w;
        bit          stall;
    } word_t;

    word_t       exp_words[$];
    logic [7:0]  exp_st[$];
    int          errors = 0;
    int          checks = 0;
    int          resp_fixed = 0;
    int          resp_rep = 0;
    int          ld_count = 0;
    int          tx_mode = 1;
    word_t       r_cur;
    int          r_d;
    logic [23:0] ow[5];
    int          cnt;
    int          kind;
    int          nb;
    int          nf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [23:0] w, input int gapmax);
        send_byte(w[23:16]);
        tick(int'($urandom_range(gapmax, 0)));
        send_byte(w[15:8]);
        tick(int'($urandom_range(gapmax, 0)));
        send_byte(w[7:0]);
    endtask

    task automatic issue(input logic [23:0] w, input bit stall, input int gapmax);
        word_t e;
        e.w     = w;
        e.stall = stall;
        exp_words.push_back(e);
        exp_st.push_back(stall ? ST_ENC_TO : ST_ACK);
        send_frame(w, gapmax);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (n < bound && !(exp_st.size() == 0 && exp_words.size() == 0 &&
                              busy === 1'b0 && tx_valid === 1'b0)) begin
            tick(1);
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL %s: still busy after %0d cycles (%0d status, %0d words outstanding), expected idle",
                     name, bound, exp_st.size(), exp_words.size());
        end
        tick(2);
    endtask

    // Status monitor: every transferred byte must be the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (exp_st.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got status %02h, expected none", tx_data);
                end else begin
                    check("tx_status", 32'(tx_data), 32'(exp_st.pop_front()));
                end
            end
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    // Encoder model: answers each load with enc_done after a delay, or never for stalled words.
    initial begin
        enc_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && enc_ld === 1'b1) begin
                ld_count++;
                if (exp_words.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL enc_ld_unexpected: got load of %06h, expected no load", enc_ad);
                end else begin
                    r_cur = exp_words[0];
                    check("enc_ad_at_ld", 32'(enc_ad), 32'(r_cur.w));
                    if (r_cur.stall) begin
                        void'(exp_words.pop_front());
                        resp_rep = 0;
                    end else begin
                        r_d = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(30, 1));
                        @(posedge clk);
                        #1;
                        repeat (r_d - 1) begin
                            @(posedge clk);
                            #1;
                        end
                        check("enc_ad_hold", 32'(enc_ad), 32'(r_cur.w));
                        enc_done = 1'b1;
                        @(posedge clk);
                        #1;
                        enc_done = 1'b0;
                        resp_rep++;
                        if (resp_rep == REPEATS) begin
                            void'(exp_words.pop_front());
                            resp_rep = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(3);
        @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_enc_ld", 32'(enc_ld), 32'd0);
        check("rst_enc_ad", 32'(enc_ad), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);

        // Single frame, fixed 50-cycle encoder response.
        resp_fixed = 50;
        ld_count   = 0;
        issue(24'hAA0155, 1'b0, 0);
        @(negedge clk);
        check("ld_latency_early", 32'(enc_ld), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ld_latency", 32'(enc_ld), 32'd1);
        tick(1);
        wait_drain("single_drain", 2000);
        check("single_ld_count", 32'(ld_count), 32'(REPEATS));
        check("single_level", 32'(level), 32'd0);

        // Overflow: four stalled words fill the FIFO, the fifth frame is refused.
        for (int i = 0; i < 5; i++) ow[i] = 24'($urandom);
        for (int i = 0; i < 4; i++) begin
            r_cur.w     = ow[i];
            r_cur.stall = 1'b1;
            exp_words.push_back(r_cur);
        end
        exp_st.push_back(ST_NAK);
        for (int i = 0; i < 4; i++) exp_st.push_back(ST_ENC_TO);
        for (int i = 0; i < 4; i++) send_frame(ow[i], 0);
        @(negedge clk);
        check("ovf_rx_ready", 32'(rx_ready), 32'd0);
        check("ovf_level_full", 32'(level), 32'd4);
        tick(1);
        send_frame(ow[4], 0);
        @(negedge clk);
        check("ovf_level_after_drop", 32'(level), 32'd4);
        tick(1);
        wait_drain("overflow_drain", 1500);

        // Gap timeout discards the partial frame.
        resp_fixed = 0;
        exp_st.push_back(ST_GAP);
        send_byte(8'h12);
        send_byte(8'h34);
        tick(GAP_TO + 1);
        issue(24'h9ABCDE, 1'b0, 0);
        wait_drain("gap_drain", 2000);

        // Encoder stall: watchdog expiry.
        issue(24'($urandom), 1'b1, 0);
        cnt = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (enc_ld === 1'b1) begin
                cnt = 0;
                break;
            end
        end
        if (cnt < 0) begin
            checks++;
            errors++;
            $display("FAIL stall_ld_seen: got no enc_ld within 50 cycles, expected one");
        end else begin
            while (cnt < 400 && tx_valid !== 1'b1) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (cnt < 100 || cnt > 104) begin
                errors++;
                $display("FAIL enc_to_latency: got %0d cycles from enc_ld to status, expected 100..104", cnt);
            end
        end
        tick(1);
        wait_drain("stall_drain", 500);
        check("stall_busy", 32'(busy), 32'd0);
        check("stall_level", 32'(level), 32'd0);

        // Status backpressure: ACK held, gap event collapses into overrun.
        tx_mode    = 0;
        resp_fixed = 3;
        issue(24'($urandom), 1'b0, 1);
        cnt = 0;
        while (cnt < 500 && tx_valid !== 1'b1) begin
            tick(1);
            cnt++;
        end
        exp_st.push_back(ST_OVR);
        send_byte(8'h77);
        tick(GAP_TO + 3);
        @(negedge clk);
        check("bp_tx_valid_held", 32'(tx_valid), 32'd1);
        check("bp_tx_data_held", 32'(tx_data), 32'(ST_ACK));
        tx_mode = 1;
        tick(1);
        wait_drain("bp_drain", 500);

        // Reset while waiting on the encoder with two words queued.
        resp_fixed = 0;
        issue(24'($urandom), 1'b1, 0);
        issue(24'($urandom), 1'b1, 0);
        tick(5);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_level", 32'(level), 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("mid_rst_enc_ld", 32'(enc_ld), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
        exp_words.delete();
        exp_st.delete();
        resp_rep = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);

        // Randomized traffic: bursts of frames or abandoned partial frames.
        tx_mode = 2;
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(9, 0));
            if (kind < 2) begin
                nb = int'($urandom_range(2, 1));
                exp_st.push_back(ST_GAP);
                repeat (nb) send_byte(8'($urandom));
                tick(GAP_TO + 2);
            end else begin
                nf = int'($urandom_range(DEPTH, 1));
                for (int f = 0; f < nf; f++) begin
                    issue(24'($urandom), ($urandom_range(7, 0) == 0), 3);
                    tick(int'($urandom_range(5, 0)));
                end
            end
            wait_drain("random_drain", 3000);
        end
        check("final_level", 32'(level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
